rv_muldiv: RTL and testbench
============================

RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have ports clk input 1 (clock) and reset_n input 1 (synchronous, active-low reset).
REQ-003 SHALL have port start input 1: operation request, sampled on the rising edge of clk.
REQ-004 SHALL have port op input 3: RISC-V M funct3 encoding (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-005 SHALL have ports a and b, input, XLEN wide: rs1 and rs2 operand values.
REQ-006 SHALL have port rd_in input 5: destination register index; 0 means no writeback.
REQ-007 SHALL have port flush input 1: abort any operation in progress.
REQ-008 SHALL have port busy output 1: high while an operation is in progress.
REQ-009 SHALL have port done output 1: single-cycle pulse when the result is valid.
REQ-010 SHALL have port rd output 5: destination index, valid with done.
REQ-011 SHALL have port c output XLEN: result, valid with done and held until the next done.

Function
REQ-012 SHALL implement four states: IDLE, CALC, FIX, DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch op, a, b and rd_in, set busy=1 on the next edge, and enter CALC, except as given in REQ-017.
REQ-014 SHALL remain in CALC for exactly XLEN cycles using a counter, processing one bit per cycle: shift-add for multiply, restoring subtract for divide.
REQ-015 SHALL take FIX for one cycle: apply sign correction for signed operations and select either the high or low XLEN bits for multiply, or the quotient or remainder for divide.
REQ-016 SHALL take DONE for one cycle with done=1, busy=0, c and rd updated, then return to IDLE; the result is visible XLEN+2 cycles after the start edge.
REQ-017 SHALL bypass CALC on divide by zero (b=0) and on signed overflow (DIV/REM with a = most-negative value and b = -1), going IDLE -> FIX -> DONE, with done asserted 2 cycles after the start edge.
REQ-018 SHALL return all-ones (quotient) and a (remainder) on divide by zero.
REQ-019 SHALL return a (quotient) and 0 (remainder) on signed overflow.
REQ-020 SHALL ignore start when not in IDLE; no request is queued.
REQ-021 SHALL ignore start in the same cycle that DONE is active; a new start is accepted from the following IDLE cycle.
REQ-022 SHALL, on flush=1 in any state, enter IDLE on the next edge with busy=0; done is not asserted and c keeps its previous value.
REQ-023 SHALL give flush priority when flush and start are both asserted in IDLE: no operation is started.
REQ-024 SHALL treat MULHSU with a signed and b unsigned; MUL returns the low XLEN bits and is identical for signed and unsigned operands.
REQ-025 SHALL compute with 2*XLEN internal product and remainder precision, with no truncation before FIX.

Reset
REQ-026 SHALL, while reset_n=0 at a clk edge, force state IDLE, busy=0, done=0, rd=0, c=0 and counter=0, including during an operation in progress (that operation is lost and no done is produced).

Configuration
REQ-027 SHALL, when RV_MULDIV_FAST_MUL_EN is defined, compute the four multiply ops with a single-cycle combinational multiplier via IDLE -> FIX -> DONE, giving done 2 cycles after start; divide timing is unchanged.
REQ-028 SHALL, when RV_MULDIV_FAST_MUL_EN is undefined, use the iterative multiplier of REQ-014, with no multiplier primitive inferred.

Verification
REQ-029 SHALL pass: XLEN=32, MULH a=0x80000000, b=0x80000000, rd_in=5 -> done at cycle 34 (2 with fast mul), c=0x40000000, rd=5.
REQ-030 SHALL pass: DIV a=-7, b=2 -> c=0xFFFFFFFD; REM with the same operands -> c=0xFFFFFFFF; each with done at cycle 34.
REQ-031 SHALL pass: DIVU a=0x1234, b=0 -> done at cycle 2, c=0xFFFFFFFF; REMU with the same operands -> c=0x1234.
REQ-032 SHALL pass: DIV a=0x80000000, b=0xFFFFFFFF -> c=0x80000000, done at cycle 2; REM with the same operands -> c=0.
REQ-033 SHALL pass: start a DIVU, pulse flush at cycle 10 -> busy=0 at cycle 11, no done, c unchanged; a following start completes normally.
REQ-034 SHALL pass: XLEN=64, MULHU a=b=0xFFFFFFFFFFFFFFFF -> c=0xFFFFFFFFFFFFFFFE, done at cycle 66; start asserted while busy has no effect.

Source files
------------

// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RISC-V M-extension multiply/divide unit.
// Define RV_MULDIV_FAST_MUL_EN to compute the multiply ops with a single-cycle multiplier.
module rv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] c
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0] op_q;
    logic [4:0] rd_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [2*XLEN-1:0] acc, acc_init, mul_nx, div_nx, prod;
    logic neg_q, rem_neg_q, zero_q, ovf_q;
    logic a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, fast, accept, ge;
    logic [XLEN-1:0] a_mag, b_mag, dif, quo, rem, res;
    logic [XLEN:0] sum, top;

    // Operands are processed as magnitudes; the sign is restored in FIX.
    assign a_sgn    = op[2] ? ~op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
    assign b_sgn    = op[2] ? ~op[0] : (op[1:0] == 2'd1);
    assign a_neg    = a_sgn & a[XLEN-1];
    assign b_neg    = b_sgn & b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = op[2] & (b == '0);
    assign div_ovf  = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    assign accept   = state == IDLE && start && !flush;

`ifdef RV_MULDIV_FAST_MUL_EN
    assign fast     = ~op[2];
    assign acc_init = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
    assign fast     = 1'b0;
    assign acc_init = {{XLEN{1'b0}}, a_mag};
`endif

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_nx = {sum, acc[XLEN-1:1]};

    // Restoring divide: partial remainder in the high half, quotient shifts into the low half.
    assign top    = acc[2*XLEN-1:XLEN-1];
    assign ge     = top >= {1'b0, b_q};
    assign dif    = top[XLEN-1:0] - b_q;
    assign div_nx = ge ? {dif, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem  = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign res  = ~op_q[2] ? (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                : ~op_q[1] ? (zero_q ? '1 : ovf_q ? a_q : quo)
                :            (zero_q ? a_q : ovf_q ? '0 : rem);

    always_comb begin
        state_nx = state;
        busy     = state == CALC || state == FIX;
        done     = state == DONE;
        case (state)
            IDLE:    state_nx = accept ? ((div_zero || div_ovf || fast) ? FIX : CALC) : IDLE;
            CALC:    state_nx = cnt == CW'(XLEN-1) ? FIX : CALC;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            c     <= '0;
            rd    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == CALC && state_nx == CALC) ? cnt + 1'b1 : '0;
            if (state == FIX && state_nx == DONE) begin
                c  <= res;
                rd <= rd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op;
            rd_q      <= rd_in;
            a_q       <= a;
            b_q       <= b_mag;
            acc       <= acc_init;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            zero_q    <= div_zero;
            ovf_q     <= div_ovf;
        end else if (state == CALC) begin
            acc <= op_q[2] ? div_nx : mul_nx;
        end
    end
endmodule

// File: tb/tb_rv_muldiv.sv
// tb_rv_muldiv: randomized and directed checks of rv_muldiv against an arithmetic reference model.
module tb_rv_muldiv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, flush;
    logic [2:0] op;
    logic [31:0] a, b, c;
    logic [4:0] rd_in, rd;
    logic busy, done;
    logic s64, f64, busy64, done64;
    logic [2:0] op64;
    logic [63:0] a64, b64, c64;
    logic [4:0] rdi64, rd64;
    int n_cmp = 0;
    int n_err = 0;

`ifdef RV_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    rv_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .rd(rd), .c(c)
    );

    rv_muldiv #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(s64), .op(op64), .a(a64), .b(b64),
        .rd_in(rdi64), .flush(f64), .busy(busy64), .done(done64), .rd(rd64), .c(c64)
    );

    function automatic logic [31:0] ref32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        int qx, qy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        qx = x;
        qy = y;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFFFFFF : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? x : 32'(qx / qy);
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: return (y == 0) ? x : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'd0 : 32'(qx % qy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2]) return (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) ? 2 : 34;
        return FAST ? 2 : 34;
    endfunction

    // Latency counts negedges after the start edge up to the first one seeing done.
    task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rd_in = r;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
        res = c;
        rdo = rd;
    endtask

    task automatic run64(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input logic [4:0] r,
                         output logic [63:0] res, output logic [4:0] rdo, output int lat);
        @(negedge clk);
        s64 = 1'b1; op64 = o; a64 = x; b64 = y; rdi64 = r;
        @(posedge clk); #1 s64 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            s64 = (lat == 5);
            if (lat == 5) begin
                n_cmp++;
                if (busy64 !== 1'b1) begin n_err++; $display("FAIL busy64_during_op: got %b want 1", busy64); end
            end
        end while (!done64 && lat < 200);
        s64 = 1'b0;
        res = c64;
        rdo = rd64;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
        s64 = 1'b0; f64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; rdi64 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (rd !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", rd); end
        n_cmp++; if (c !== 32'd0) begin n_err++; $display("FAIL reset_c: got %h want 0", c); end
        n_cmp++; if (c64 !== 64'd0) begin n_err++; $display("FAIL reset_c64: got %h want 0", c64); end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [7] = '{3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] t_a  [7] = '{32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
        logic [31:0] t_b  [7] = '{32'h80000000, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_c  [7] = '{32'h40000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0};
        int          t_l  [7] = '{FAST ? 2 : 34, 34, 34, 2, 2, 2, 2};
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run32(t_op[i], t_a[i], t_b[i], 5'(5 + i), res, rdo, lat);
            n_cmp++; if (res !== t_c[i]) begin n_err++; $display("FAIL directed%0d_c: got %h want %h", i, res, t_c[i]); end
            n_cmp++; if (rdo !== 5'(5 + i)) begin n_err++; $display("FAIL directed%0d_rd: got %0d want %0d", i, rdo, 5 + i); end
            n_cmp++; if (lat != t_l[i]) begin n_err++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, t_l[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, res;
        logic [2:0] o;
        logic [4:0] r, rdo;
        int lat, mode;
        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            r = 5'($urandom_range(0, 31));
            mode = $urandom_range(0, 5);
            if (mode == 0) y = 32'd0;
            if (mode == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            if (mode == 2) y = $urandom_range(1, 15);
            if (mode == 3) y = 32'hFFFFFFFF - $urandom_range(0, 8);
            run32(o, x, y, r, res, rdo, lat);
            n_cmp++; if (res !== ref32(o, x, y)) begin n_err++; $display("FAIL random%0d_c op=%0d a=%h b=%h: got %h want %h", i, o, x, y, res, ref32(o, x, y)); end
            n_cmp++; if (rdo !== r) begin n_err++; $display("FAIL random%0d_rd: got %0d want %0d", i, rdo, r); end
            n_cmp++; if (lat != lat32(o, x, y)) begin n_err++; $display("FAIL random%0d_latency op=%0d: got %0d want %0d", i, o, lat, lat32(o, x, y)); end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7; rd_in = 5'd3;
        @(posedge clk); #1 start = 1'b0;
        op = 3'd0; a = 32'd5; b = 32'd6; rd_in = 5'd9;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 3);
            if (lat == 3) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_during_op: got %b want 1", busy); end
            end
        end while (!done && lat < 100);
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL ignore_start_latency: got %0d want 34", lat); end
        n_cmp++; if (c !== 32'd142) begin n_err++; $display("FAIL ignore_start_c: got %h want %h", c, 32'd142); end
        n_cmp++; if (rd !== 5'd3) begin n_err++; $display("FAIL ignore_start_rd: got %0d want 3", rd); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_in_done_busy: got %b want 0", busy); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL start_not_queued: got done=%b want 0", seen); end
    endtask

    task automatic test_flush();
        logic [31:0] c_before, res;
        logic [4:0] rdo;
        int lat;
        bit seen;
        c_before = c;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hFFFF; b = 32'd3; rd_in = 5'd8;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_before: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b want 0", seen); end
        n_cmp++; if (c !== c_before) begin n_err++; $display("FAIL flush_c_kept: got %h want %h", c, c_before); end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_priority: got %b want 0", busy); end
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd77; b = 32'd0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (done) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_in_fix_no_done: got %b want 0", seen); end
        n_cmp++; if (c !== c_before) begin n_err++; $display("FAIL flush_in_fix_c_kept: got %h want %h", c, c_before); end
        run32(3'd5, 32'd9, 32'd3, 5'd4, res, rdo, lat);
        n_cmp++; if (res !== 32'd3) begin n_err++; $display("FAIL after_flush_c: got %h want 3", res); end
        n_cmp++; if (rdo !== 5'd4) begin n_err++; $display("FAIL after_flush_rd: got %0d want 4", rdo); end
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL after_flush_latency: got %0d want 34", lat); end
    endtask

    task automatic test_reset_midop();
        bit seen;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd3; rd_in = 5'd9;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midop_reset_busy: got %b want 0", busy); end
        n_cmp++; if (c !== 32'd0) begin n_err++; $display("FAIL midop_reset_c: got %h want 0", c); end
        n_cmp++; if (rd !== 5'd0) begin n_err++; $display("FAIL midop_reset_rd: got %0d want 0", rd); end
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midop_reset_no_done: got %b want 0", seen); end
    endtask

    task automatic test_xlen64();
        logic [63:0] res, x, y;
        logic [127:0] p;
        logic [4:0] rdo;
        int lat;
        bit seen;
        run64(3'd3, '1, '1, 5'd7, res, rdo, lat);
        n_cmp++; if (res !== 64'hFFFFFFFFFFFFFFFE) begin n_err++; $display("FAIL x64_mulhu_c: got %h want fffffffffffffffe", res); end
        n_cmp++; if (rdo !== 5'd7) begin n_err++; $display("FAIL x64_mulhu_rd: got %0d want 7", rdo); end
        n_cmp++; if (lat != (FAST ? 2 : 66)) begin n_err++; $display("FAIL x64_mulhu_latency: got %0d want %0d", lat, FAST ? 2 : 66); end
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (done64 || busy64) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL x64_start_not_queued: got %b want 0", seen); end
        x = {$urandom, $urandom};
        y = {32'd0, $urandom} | 64'd1;
        run64(3'd5, x, y, 5'd11, res, rdo, lat);
        n_cmp++; if (res !== x / y) begin n_err++; $display("FAIL x64_divu_c: got %h want %h", res, x / y); end
        n_cmp++; if (lat != 66) begin n_err++; $display("FAIL x64_divu_latency: got %0d want 66", lat); end
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        p = {{64{x[63]}}, x} * {{64{y[63]}}, y};
        run64(3'd1, x, y, 5'd12, res, rdo, lat);
        n_cmp++; if (res !== p[127:64]) begin n_err++; $display("FAIL x64_mulh_c: got %h want %h", res, p[127:64]); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_flush();
        test_reset_midop();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
